demux_1_n_stream: RTL and testbench

//  Parametrised successor to the 1:2 combinational demux. Routes one input stream to
//  one of N output channels selected per transfer, with valid/ready handshakes on

---
 rtl/demux_pkg.sv | 10 +
 rtl/demux_slot.sv | 35 +++
 rtl/demux_1_n_stream.sv | 74 +++++++
 tb/tb_demux_1_n_stream.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and slot state encoding for the 1:N stream demux.
package demux_pkg;
  localparam int DROP_CNT_W = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'hFF;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;
endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single demux output channel.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             drain,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  slot_state_e state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SLOT_EMPTY;
      q     <= '0;
    end else begin
      case (state)
        SLOT_EMPTY: if (load) state <= SLOT_FULL;
        SLOT_FULL:  if (drain && !load) state <= SLOT_EMPTY;
        default:    state <= SLOT_EMPTY;
      endcase
      // q is only ever overwritten by a load, so it keeps its value while empty
      if (load) q <= d;
    end
  end

  assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/demux_1_n_stream.sv
// 1:N valid/ready stream demux with per-channel holding registers.
// Optional broadcast port i_bcast is enabled by defining DEMUX_BCAST_EN.
module demux_1_n_stream
  import demux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      i_data,
  input  logic [SEL_W-1:0]      i_sel,
  input  logic                  i_valid,
`ifdef DEMUX_BCAST_EN
  input  logic                  i_bcast,
`endif
  output logic                  i_ready,
  output logic [N*WIDTH-1:0]    o_data,
  output logic [N-1:0]          o_valid,
  input  logic [N-1:0]          o_ready,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  logic [N-1:0] sel_hit;
  logic [N-1:0] load_vec;
  logic         in_range;
  logic         uni_ready;
  logic         accept;
  logic         drop;

  always_comb begin
    sel_hit = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sel_hit[k] = (i_sel == SEL_W'(k));
    end
  end

  // Out-of-range selects are always accepted so they can be discarded and counted
  assign in_range  = |sel_hit;
  assign uni_ready = ~in_range | (|(sel_hit & (~o_valid | o_ready)));
  assign accept    = i_valid & i_ready;

`ifdef DEMUX_BCAST_EN
  assign i_ready  = i_bcast ? (&(~o_valid | o_ready)) : uni_ready;
  assign load_vec = accept ? (i_bcast ? '1 : sel_hit) : '0;
  assign drop     = accept & ~i_bcast & ~in_range;
`else
  assign i_ready  = uni_ready;
  assign load_vec = accept ? sel_hit : '0;
  assign drop     = accept & ~in_range;
`endif

  for (genvar k = 0; k < N; k++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_vec[k]),
      .d     (i_data),
      .drain (o_ready[k]),
      .valid (o_valid[k]),
      .q     (o_data[k*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != DROP_CNT_MAX)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_1_n_stream.sv
// Scoreboard bench for demux_1_n_stream (N=4 main instance, N=3 drop-counter instance).
module tb_demux_1_n_stream;
  localparam int W = 8;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [W-1:0]     i_data;
  logic [1:0]       i_sel;
  logic             i_valid;
  logic             i_ready;
  logic [N*W-1:0]   o_data;
  logic [N-1:0]     o_valid;
  logic [N-1:0]     o_ready;
  logic [7:0]       drop_cnt;

  logic [W-1:0]     d3_data;
  logic [1:0]       d3_sel;
  logic             d3_valid;
  logic             d3_i_ready;
  logic [3*W-1:0]   d3_o_data;
  logic [2:0]       d3_o_valid;
  logic [2:0]       d3_o_ready;
  logic [7:0]       d3_drop;
`ifdef DEMUX_BCAST_EN
  logic             i_bcast;
  logic             d3_bcast;
`endif

  always #5 clk = ~clk;

  demux_1_n_stream #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_sel(i_sel), .i_valid(i_valid),
`ifdef DEMUX_BCAST_EN
    .i_bcast(i_bcast),
`endif
    .i_ready(i_ready), .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
    .drop_cnt(drop_cnt)
  );

  demux_1_n_stream #(.WIDTH(W), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_data(d3_data), .i_sel(d3_sel), .i_valid(d3_valid),
`ifdef DEMUX_BCAST_EN
    .i_bcast(d3_bcast),
`endif
    .i_ready(d3_i_ready), .o_data(d3_o_data), .o_valid(d3_o_valid), .o_ready(d3_o_ready),
    .drop_cnt(d3_drop)
  );

  typedef struct {
    int         ch;
    logic [W-1:0] data;
  } exp_t;

  exp_t         exp_q[$];
  logic [N-1:0] mv;
  logic [W-1:0] md [N];
  int           mdrop;
  int           n_total = 0;
  int           n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mv = '0;
    for (int k = 0; k < N; k++) md[k] = '0;
    mdrop = 0;
    exp_q.delete();
  endtask

  task automatic step(input logic [1:0] sel, input logic [W-1:0] data, input logic vld,
                      input logic [N-1:0] rdy, input logic bc);
    logic exp_rdy;
    logic acc;
    exp_t e;
    @(negedge clk);
    i_sel   = sel;
    i_data  = data;
    i_valid = vld;
    o_ready = rdy;
`ifdef DEMUX_BCAST_EN
    i_bcast = bc;
`endif
    #1;
    if (bc) exp_rdy = &(~mv | rdy);
    else    exp_rdy = (int'(sel) >= N) || !mv[sel] || rdy[sel];
    check("i_ready", 64'(i_ready), 64'(exp_rdy));
    acc = vld & exp_rdy;
    mv  = mv & ~(mv & rdy);
    if (acc) begin
      if (bc) begin
        for (int k = 0; k < N; k++) begin
          mv[k] = 1'b1;
          md[k] = data;
          e.ch = k; e.data = data;
          exp_q.push_back(e);
        end
      end else if (int'(sel) < N) begin
        mv[sel] = 1'b1;
        md[sel] = data;
        e.ch = int'(sel); e.data = data;
        exp_q.push_back(e);
      end else if (mdrop < 255) begin
        mdrop++;
      end
    end
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ch_data", 64'(o_data[e.ch*W +: W]), 64'(e.data));
      check("ch_valid", 64'(o_valid[e.ch]), 64'd1);
    end
    check("o_valid", 64'(o_valid), 64'(mv));
    check("drop_cnt", 64'(drop_cnt), 64'(mdrop));
    for (int k = 0; k < N; k++) check("hold", 64'(o_data[k*W +: W]), 64'(md[k]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    i_sel = '0; i_data = '0; i_valid = 1'b0; o_ready = '0;
    d3_sel = '0; d3_data = '0; d3_valid = 1'b0; d3_o_ready = '0;
`ifdef DEMUX_BCAST_EN
    i_bcast = 1'b0; d3_bcast = 1'b0;
`endif
    model_reset();

    // reset held with random inputs: nothing may be accepted
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      i_sel   = 2'($urandom_range(0, 3));
      i_data  = 8'($urandom);
      i_valid = 1'($urandom);
      o_ready = 4'($urandom);
      @(posedge clk);
      #1;
      check("rst_o_valid", 64'(o_valid), 64'd0);
      check("rst_o_data", 64'(o_data), 64'd0);
      check("rst_drop", 64'(drop_cnt), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(2'd0, 8'h00, 1'b0, 4'hF, 1'b0);
    step(2'd1, 8'h00, 1'b0, 4'h0, 1'b0);

    // unicast to channel 2
    step(2'd2, 8'hA5, 1'b1, 4'hF, 1'b0);
    step(2'd2, 8'h00, 1'b0, 4'hF, 1'b0);

    // stall isolation on channel 1
    step(2'd1, 8'h11, 1'b1, 4'b1101, 1'b0);
    step(2'd1, 8'h22, 1'b1, 4'b1101, 1'b0);
    step(2'd3, 8'h33, 1'b1, 4'b1101, 1'b0);
    step(2'd1, 8'h22, 1'b1, 4'b1111, 1'b0);

    // drain and load on the same edge
    step(2'd0, 8'h01, 1'b1, 4'h0, 1'b0);
    step(2'd0, 8'h02, 1'b1, 4'hF, 1'b0);
    step(2'd0, 8'h00, 1'b0, 4'hF, 1'b0);

    // random traffic against the model
    for (int i = 0; i < 200; i++) begin
      step(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 4'($urandom), 1'b0);
    end

    // reset asserted with held data discards it immediately
    step(2'd2, 8'h77, 1'b1, 4'h0, 1'b0);
    @(negedge clk);
    i_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(o_valid), 64'd0);
    check("async_rst_data", 64'(o_data), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(2'd0, 8'h00, 1'b0, 4'h0, 1'b0);

`ifdef DEMUX_BCAST_EN
    // broadcast blocked by one stalled full channel, then released
    step(2'd1, 8'h44, 1'b1, 4'b1101, 1'b0);
    step(2'd0, 8'h5A, 1'b1, 4'b1101, 1'b1);
    step(2'd0, 8'h5A, 1'b1, 4'b1111, 1'b1);
    step(2'd0, 8'h00, 1'b0, 4'b0000, 1'b0);
`endif

    // N=3 instance: out-of-range select discarded and counted, saturating
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      d3_sel     = 2'd3;
      d3_data    = 8'($urandom);
      d3_valid   = 1'b1;
      d3_o_ready = 3'($urandom);
      #1;
      check("n3_i_ready", 64'(d3_i_ready), 64'd1);
      @(posedge clk);
      #1;
      check("n3_drop", 64'(d3_drop), 64'((i + 1 < 255) ? i + 1 : 255));
    end
    check("n3_o_valid", 64'(d3_o_valid), 64'd0);
    @(negedge clk);
    d3_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
